matrix_skew_dispatcher: RTL and testbench

// - Parametrised Matrix Padding Unit. Captures an NxN matrix on a start handshake.
// - Feeds the matrix to the systolic-array TPU as a skewed (diagonal) wavefront.
// - Pads zeros where a lane is outside its active window, then flushes with zeros
//   and signals completion.
// - Sits between the matrix buffer and the TPU row inputs.
// - Supports any MATRIX_SIZE, a programmable flush length and back-to-back jobs.

---
 rtl/matrix_skew_dispatcher.sv | 124 ++++++++++++
 tb/tb_matrix_skew_dispatcher.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_skew_dispatcher.sv
// Captures an NxN matrix on start and streams it to the TPU as a skewed wavefront,
// followed by FLUSH_CYCLES zero beats and a done pulse. Optional macro: MPU_TRANSPOSE_EN.
//
// state | meaning
// IDLE  | waiting for start (ready=1 once the previous job has fully retired)
// FEED  | step counter walks 0..2N-2, one wavefront beat per cycle
// FLUSH | FLUSH_CYCLES all-zero beats with TPU_valid low
// DONE  | one-cycle done pulse, then back to IDLE
module matrix_skew_dispatcher #(
  parameter int MATRIX_SIZE  = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   flattened_array_input,
  input  logic                                            start,
`ifdef MPU_TRANSPOSE_EN
  input  logic                                            transpose,
`endif
  output logic                                            ready,
  output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]          TPU_inarray,
  output logic                                            TPU_valid,
  output logic                                            done
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(2 * N);
  localparam logic [SW-1:0] T_LAST = SW'(2 * N - 2);
  localparam logic [3:0]    F_LAST = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SW-1:0]          step;
  logic [3:0]             fcnt;
  logic [N*N*DW-1:0]      cap;
  logic [N-1:0][DW-1:0]   lane_nxt;
  logic                   accept;
`ifdef MPU_TRANSPOSE_EN
  logic                   xpose;
`endif

  assign accept = (state == IDLE) && ready && start;

  function automatic logic [DW-1:0] elem(input logic [N*N*DW-1:0] m, input int r, input int c);
    return m[(N*N-1-(r*N+c))*DW +: DW];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FEED;
      FEED:    if (step == T_LAST) state_nxt = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
      FLUSH:   if (fcnt == F_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters sit at zero outside their own state, so they start cleared on entry and never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      fcnt <= '0;
    end else begin
      step <= (state == FEED  && step != T_LAST) ? step + 1'b1 : '0;
      fcnt <= (state == FLUSH && fcnt != F_LAST) ? fcnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap   <= '0;
`ifdef MPU_TRANSPOSE_EN
      xpose <= 1'b0;
`endif
    end else if (accept) begin
      cap   <= flattened_array_input;
`ifdef MPU_TRANSPOSE_EN
      xpose <= transpose;
`endif
    end
  end

  // Lane k carries row (or column) N-1-k, delayed by that index to form the diagonal.
  always_comb begin
    lane_nxt = '0;
    if (state == FEED) begin
      for (int k = 0; k < N; k++) begin
        if (int'(step) >= N - 1 - k && int'(step) - (N - 1 - k) < N) begin
`ifdef MPU_TRANSPOSE_EN
          lane_nxt[k] = xpose ? elem(cap, int'(step) - (N - 1 - k), N - 1 - k)
                              : elem(cap, N - 1 - k, int'(step) - (N - 1 - k));
`else
          lane_nxt[k] = elem(cap, N - 1 - k, int'(step) - (N - 1 - k));
`endif
        end
      end
    end
  end

  // Outputs trail the state by one cycle; ready only rises after a full IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TPU_inarray <= '0;
      TPU_valid   <= 1'b0;
      done        <= 1'b0;
      ready       <= 1'b1;
    end else begin
      TPU_inarray <= lane_nxt;
      TPU_valid   <= (state == FEED);
      done        <= (state == DONE);
      ready       <= (state == IDLE) && !accept;
    end
  end

endmodule

// File: tb/tb_matrix_skew_dispatcher.sv
// Directed bench for matrix_skew_dispatcher; expected beats are queued when a job is
// accepted and popped one per cycle. Exercises the transpose mode when MPU_TRANSPOSE_EN is set.
module tb_matrix_skew_dispatcher;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int F  = 2;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic [N*N*DW-1:0]    flat  = '0;
  logic [N-1:0][DW-1:0] lanes;
  logic                 valid, done, ready;
`ifdef MPU_TRANSPOSE_EN
  logic                 transpose = 1'b0;
`endif

  matrix_skew_dispatcher #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .FLUSH_CYCLES(F)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flattened_array_input (flat),
    .start                 (start),
`ifdef MPU_TRANSPOSE_EN
    .transpose             (transpose),
`endif
    .ready                 (ready),
    .TPU_inarray           (lanes),
    .TPU_valid             (valid),
    .done                  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*DW-1:0] lanes;
    logic            valid;
    logic            done;
    logic            ready;
  } exp_t;

  exp_t              sb[$];
  int                vectors     = 0;
  int                miscompares = 0;
  logic              prev_ready  = 1'b1;
  logic [N*N*DW-1:0] mat_a, mat_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] a_elem(input logic [N*N*DW-1:0] m, input int r, input int c);
    return m[(N*N-1-(r*N+c))*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] beat(input logic [N*N*DW-1:0] m, input logic xp, input int t);
    logic [N*DW-1:0] res = '0;
    for (int k = 0; k < N; k++) begin
      int r = N - 1 - k;
      int c = t - r;
      if (c >= 0 && c < N) res[k*DW +: DW] = xp ? a_elem(m, c, r) : a_elem(m, r, c);
    end
    return res;
  endfunction

  task automatic push_job(input logic [N*N*DW-1:0] m, input logic xp);
    sb.push_back('{lanes: '0, valid: 1'b0, done: 1'b0, ready: 1'b0});
    for (int t = 0; t < 2*N-1; t++)
      sb.push_back('{lanes: beat(m, xp, t), valid: 1'b1, done: 1'b0, ready: 1'b0});
    for (int f = 0; f < F; f++)
      sb.push_back('{lanes: '0, valid: 1'b0, done: 1'b0, ready: 1'b0});
    sb.push_back('{lanes: '0, valid: 1'b0, done: 1'b1, ready: 1'b0});
  endtask

  // One clock: predict acceptance, advance past the edge, then compare against the scoreboard.
  task automatic tick();
    exp_t e;
    logic xp = 1'b0;
`ifdef MPU_TRANSPOSE_EN
    xp = transpose;
`endif
    if (start && rst_n && prev_ready) push_job(flat, xp);
    @(posedge clk);
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else               e = '{lanes: '0, valid: 1'b0, done: 1'b0, ready: rst_n ? 1'b1 : 1'b1};
    chk("lanes", 64'(lanes), 64'(e.lanes));
    chk("valid", 64'(valid), 64'(e.valid));
    chk("done",  64'(done),  64'(e.done));
    chk("ready", 64'(ready), 64'(e.ready));
    prev_ready = e.ready;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N*N; i++) begin
      mat_a[(N*N-1-i)*DW +: DW] = DW'(i + 1);
      mat_b[(N*N-1-i)*DW +: DW] = DW'(8'hA0 + i);
    end

    #2 rst_n = 1'b0;
    #1;
    chk("rst_lanes", 64'(lanes), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    #9 rst_n = 1'b1;
    tick();
    tick();

    // Job 1: spec vectors at steps 0, 3 and 6, then flush, done and ready.
    flat  = mat_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) chk("step0", 64'(lanes), 64'h01000000);
      if (i == 4) chk("step3", 64'(lanes), 64'h04070A0D);
      if (i == 7) chk("step6", 64'(lanes), 64'h00000010);
      if (i == 10) chk("done_e10", 64'(done), 64'd1);
      if (i == 11) chk("ready_e11", 64'(ready), 64'd1);
    end

    // Job 2: input changed mid-FEED and a stray start pulse while busy.
    flat  = mat_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 3) flat = mat_b;
      start = (i == 5);
      tick();
    end
    start = 1'b0;

    // Start held high: back-to-back jobs one IDLE cycle apart.
    flat  = mat_b;
    start = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("drain", 64'(sb.size()), 64'd0);
    tick();

    // Reset at step 3 aborts at once; start during reset is ignored.
    flat  = mat_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_lanes", 64'(lanes), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done",  64'(done),  64'd0);
    sb.delete();
    prev_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    flat  = mat_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("replay_step0", 64'(lanes), 64'h01000000);
    for (int i = 2; i <= 12; i++) tick();

`ifdef MPU_TRANSPOSE_EN
    transpose = 1'b1;
    flat      = mat_a;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    transpose = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) chk("xp_step0", 64'(lanes), 64'h01000000);
      if (i == 4) chk("xp_step3", 64'(lanes), 64'h0D0A0704);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
